// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
// Register 0 reads as zero and is never busy; higher write port index wins on address collisions.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   writeaddr,
    input  logic [NWR*XLEN-1:0] writedata,
    input  logic [NRD*AW-1:0]   readaddr,
    output logic [NRD*XLEN-1:0] readdata,
    output logic [NRD-1:0]      readbusy,
    input  logic                issue,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic [AW-1:0]    waddr [NWR];
    logic [XLEN-1:0]  wdata [NWR];
    logic [AW-1:0]    raddr [NRD];

    for (genvar i = 0; i < NWR; i++) begin : g_wr_unpack
        assign waddr[i] = writeaddr[i*AW +: AW];
        assign wdata[i] = writedata[i*XLEN +: XLEN];
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd_unpack
        assign raddr[r] = readaddr[r*AW +: AW];
    end

    // Ports are applied in ascending order so the highest index overwrites lower ones.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (we[i] && (waddr[i] != '0)) begin
                mem_d[waddr[i]] = wdata[i];
            end
        end
        mem_d[0] = '0;
    end

    // Flush, then writeback clears, then issue sets: issue wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        for (int unsigned i = 0; i < NWR; i++) begin
            if (we[i]) begin
                busy_d[waddr[i]] = 1'b0;
            end
        end
        if (issue) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        readdata = '0;
        readbusy = '0;
        for (int unsigned r = 0; r < NRD; r++) begin
            if (raddr[r] != '0) begin
                readdata[r*XLEN +: XLEN] = mem_q[raddr[r]];
                readbusy[r]              = busy_q[raddr[r]];
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (we[i] && (waddr[i] == raddr[r])) begin
                        readdata[r*XLEN +: XLEN] = wdata[i];
                        readbusy[r]              = 1'b0;
                    end
                end
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NREGS=16, XLEN=64, NRD=4, NWR=3): directed scenarios then
// randomized traffic, predicted by an array-based model and checked by a negedge monitor.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 16;
    localparam int unsigned NRD   = 4;
    localparam int unsigned NWR   = 3;
    localparam int unsigned AW    = 4;

    logic                clk;
    logic                rst;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   writeaddr;
    logic [NWR*XLEN-1:0] writedata;
    logic [NRD*AW-1:0]   readaddr;
    logic [NRD*XLEN-1:0] readdata;
    logic [NRD-1:0]      readbusy;
    logic                issue;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;

    regfile_mp #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .writeaddr(writeaddr),
        .writedata(writedata),
        .readaddr (readaddr),
        .readdata (readdata),
        .readbusy (readbusy),
        .issue    (issue),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int                  id;
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      rb;
        logic [NREGS-1:0]    bv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Stimulus for the next cycle
    logic            s_rst;
    logic            s_we [NWR];
    logic [AW-1:0]   s_wa [NWR];
    logic [XLEN-1:0] s_wd [NWR];
    logic [AW-1:0]   s_ra [NRD];
    logic            s_issue;
    logic [AW-1:0]   s_ird;
    logic            s_flush;

    // Reference model
    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_busy;

    task automatic chk(input string name, input int id, input logic [NRD*XLEN-1:0] act,
                       input logic [NRD*XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, id, act, exp);
    endtask

    task automatic idle();
        for (int i = 0; i < NWR; i++) s_we[i] = 1'b0;
        s_issue = 1'b0;
        s_flush = 1'b0;
        s_rst   = 1'b0;
    endtask

    task automatic step();
        exp_t            e;
        logic [XLEN-1:0] val;
        logic            hit;
        @(posedge clk);
        #1;
        cyc++;
        rst = s_rst;
        for (int i = 0; i < NWR; i++) begin
            we[i]                    = s_we[i];
            writeaddr[i*AW +: AW]    = s_wa[i];
            writedata[i*XLEN +: XLEN] = s_wd[i];
        end
        for (int r = 0; r < NRD; r++) readaddr[r*AW +: AW] = s_ra[r];
        issue    = s_issue;
        issue_rd = s_ird;
        flush    = s_flush;

        if (s_rst) begin
            for (int k = 0; k < NREGS; k++) m_mem[k] = '0;
            m_busy = '0;
        end

        e.id = cyc;
        e.rd = '0;
        e.rb = '0;
        e.bv = m_busy;
        for (int r = 0; r < NRD; r++) begin
            if (s_ra[r] != '0) begin
                val = m_mem[s_ra[r]];
                hit = 1'b0;
                // Search from the highest-priority port down; first hit is the bypass source.
                for (int i = NWR - 1; i >= 0; i--) begin
                    if (!hit && s_we[i] && (s_wa[i] == s_ra[r])) begin
                        val = s_wd[i];
                        hit = 1'b1;
                    end
                end
                e.rd[r*XLEN +: XLEN] = val;
                e.rb[r]              = m_busy[s_ra[r]] && !hit;
            end
        end
        sb.push_back(e);

        if (!s_rst) begin
            for (int i = 0; i < NWR; i++) begin
                if (s_we[i] && (s_wa[i] != '0)) m_mem[s_wa[i]] = s_wd[i];
            end
            if (s_flush) m_busy = '0;
            for (int i = 0; i < NWR; i++) begin
                if (s_we[i]) m_busy[s_wa[i]] = 1'b0;
            end
            if (s_issue && (s_ird != '0)) m_busy[s_ird] = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("readdata", e.id, readdata, e.rd);
                chk("readbusy", e.id, {{(NRD*XLEN-NRD){1'b0}}, readbusy},
                    {{(NRD*XLEN-NRD){1'b0}}, e.rb});
                chk("busy_vec", e.id, {{(NRD*XLEN-NREGS){1'b0}}, busy_vec},
                    {{(NRD*XLEN-NREGS){1'b0}}, e.bv});
            end
        end
    end

    initial begin : driver
        rst       = 1'b1;
        we        = '0;
        writeaddr = '0;
        writedata = '0;
        readaddr  = '0;
        issue     = 1'b0;
        issue_rd  = '0;
        flush     = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            s_wa[i] = '0;
            s_wd[i] = '0;
        end
        for (int r = 0; r < NRD; r++) s_ra[r] = '0;
        s_ird = '0;
        idle();
        for (int k = 0; k < NREGS; k++) m_mem[k] = '0;
        m_busy = '0;

        // Reset held: sweep every register across all read ports
        s_rst = 1'b1;
        for (int k = 0; k < NREGS / NRD; k++) begin
            for (int r = 0; r < NRD; r++) s_ra[r] = AW'(k * NRD + r);
            step();
        end
        idle();
        step();

        // Single write with bypass, then from storage
        s_we[0] = 1'b1; s_wa[0] = AW'(5); s_wd[0] = 64'h0000_0000_1234_5678;
        s_ra[0] = AW'(5); s_ra[1] = AW'(5); s_ra[2] = AW'(5); s_ra[3] = AW'(5);
        step();
        idle();
        step();

        // Two ports to the same address: port 1 wins
        s_we[0] = 1'b1; s_wa[0] = AW'(7); s_wd[0] = 64'h0000_0000_AAAA_0000;
        s_we[1] = 1'b1; s_wa[1] = AW'(7); s_wd[1] = 64'h0000_0000_5555_FFFF;
        s_ra[0] = AW'(7); s_ra[1] = AW'(7); s_ra[2] = AW'(5); s_ra[3] = AW'(0);
        step();
        idle();
        step();

        // Three ports to one address: port 2 wins
        s_we[0] = 1'b1; s_wa[0] = AW'(4); s_wd[0] = 64'h1111_1111_1111_1111;
        s_we[1] = 1'b1; s_wa[1] = AW'(4); s_wd[1] = 64'h2222_2222_2222_2222;
        s_we[2] = 1'b1; s_wa[2] = AW'(4); s_wd[2] = 64'h3333_3333_3333_3333;
        s_ra[0] = AW'(4); s_ra[1] = AW'(4); s_ra[2] = AW'(4); s_ra[3] = AW'(4);
        step();
        idle();
        step();

        // Writes to register 0 are discarded
        s_we[0] = 1'b1; s_wa[0] = AW'(0); s_wd[0] = '1;
        s_we[1] = 1'b1; s_wa[1] = AW'(0); s_wd[1] = '1;
        s_ra[0] = AW'(0); s_ra[1] = AW'(0); s_ra[2] = AW'(7); s_ra[3] = AW'(4);
        step();
        idle();
        step();

        // Issue 9, observe busy, writeback clears it
        s_issue = 1'b1; s_ird = AW'(9);
        s_ra[0] = AW'(9); s_ra[1] = AW'(9); s_ra[2] = AW'(9); s_ra[3] = AW'(9);
        step();
        idle();
        step();
        s_we[1] = 1'b1; s_wa[1] = AW'(9); s_wd[1] = 64'hCAFE_F00D_0000_0009;
        step();
        idle();
        step();

        // Issue wins over same-cycle writeback and flush
        s_issue = 1'b1; s_ird = AW'(2);
        step();
        s_issue = 1'b1; s_ird = AW'(6);
        s_ra[0] = AW'(2); s_ra[1] = AW'(6); s_ra[2] = AW'(3); s_ra[3] = AW'(9);
        step();
        s_issue = 1'b1; s_ird = AW'(3); s_flush = 1'b1;
        s_we[0] = 1'b1; s_wa[0] = AW'(3); s_wd[0] = 64'h0000_0000_0000_0033;
        step();
        idle();
        s_issue = 1'b1; s_ird = AW'(0);
        s_ra[0] = AW'(0);
        step();
        idle();
        step();

        // Asynchronous reset between edges clears stored data immediately
        s_we[2] = 1'b1; s_wa[2] = AW'(11); s_wd[2] = 64'h0000_0000_DEAD_BEEF;
        s_issue = 1'b1; s_ird = AW'(11);
        s_ra[0] = AW'(11); s_ra[1] = AW'(3); s_ra[2] = AW'(5); s_ra[3] = AW'(7);
        step();
        idle();
        step();
        s_rst = 1'b1;
        step();
        idle();
        step();

        // Randomized traffic over a narrow address window to provoke collisions
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NWR; i++) begin
                s_we[i] = ($urandom_range(0, 1) == 1);
                s_wa[i] = AW'($urandom_range(0, 7));
                s_wd[i] = {$urandom(), $urandom()};
            end
            for (int r = 0; r < NRD; r++) s_ra[r] = AW'($urandom_range(0, 7));
            s_issue = ($urandom_range(0, 2) == 0);
            s_ird   = AW'($urandom_range(0, 7));
            s_flush = ($urandom_range(0, 15) == 0);
            s_rst   = 1'b0;
            step();
        end
        idle();
        step();

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
